// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream decode inputs and the execute-side ALU request.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready handshakes on each side.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;

    // The issue stage itself: consumes the upstream word, produces the ALU request.
    modport master (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, alu_op, operand_a, operand_b, rd, rd_we, illegal
    );

    // The surrounding pipeline: register-file read upstream, execute downstream.
    modport slave (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, alu_op, operand_a, operand_b, rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decoder (OP, OP-IMM, LUI, AUIPC) into a valid/ready output register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: default in_ready = !out_valid || out_ready; with ALU_ISSUE_SKID_EN a
// one-entry skid buffer makes in_ready a registered "skid empty" flag.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_issue_stage_if.master   bus
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } uop_t;

    localparam uop_t UOP_RST = '{op: `ALU_ADD, a: '0, b: '0, rd: '0, we: 1'b0, ill: 1'b0};

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    logic            legal;
    logic [3:0]      op_c;
    logic [XLEN-1:0] a_c;
    logic [XLEN-1:0] b_c;
    uop_t            dec;

    uop_t            out_q;
    logic            out_valid_q;
    logic            in_fire;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];
    assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_u  = {bus.in_instr[31:12], 12'b0};
    assign shamt  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

    // Decode the incoming word into opcode and operands; illegal encodings collapse to a harmless ADD 0,0.
    always_comb begin
        legal = 1'b1;
        op_c  = `ALU_ADD;
        a_c   = '0;
        b_c   = '0;
        unique case (opcode)
            OPC_OP_IMM: begin
                a_c = bus.in_rs1_data;
                b_c = imm_i;
                unique case (funct3)
                    3'b000: op_c = `ALU_ADD;
                    3'b010: op_c = `ALU_SLT;
                    3'b011: op_c = `ALU_SLTU;
                    3'b100: op_c = `ALU_XOR;
                    3'b110: op_c = `ALU_OR;
                    3'b111: op_c = `ALU_AND;
                    3'b001: begin
                        b_c   = shamt;
                        op_c  = `ALU_SLL;
                        legal = (funct7 == F7_BASE);
                    end
                    default: begin
                        b_c = shamt;
                        if (funct7 == F7_BASE) begin
                            op_c = `ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op_c = `ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                a_c = bus.in_rs1_data;
                b_c = bus.in_rs2_data;
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000:  op_c = `ALU_ADD;
                        3'b001:  op_c = `ALU_SLL;
                        3'b010:  op_c = `ALU_SLT;
                        3'b011:  op_c = `ALU_SLTU;
                        3'b100:  op_c = `ALU_XOR;
                        3'b101:  op_c = `ALU_SRL;
                        3'b110:  op_c = `ALU_OR;
                        default: op_c = `ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    op_c = `ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    op_c = `ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_LUI: begin
                b_c = imm_u;
            end
            OPC_AUIPC: begin
                a_c = bus.in_pc;
                b_c = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op_c = `ALU_ADD;
            a_c  = '0;
            b_c  = '0;
        end
        dec.op  = op_c;
        dec.a   = a_c;
        dec.b   = b_c;
        dec.rd  = bus.in_instr[11:7];
        dec.we  = legal && (bus.in_instr[11:7] != 5'd0);
        dec.ill = !legal;
    end

    assign in_fire = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_SKID_EN
    uop_t skid_q;
    logic skid_empty_q;

    assign bus.in_ready = skid_empty_q;

    // Output register refills from the skid entry first so order is preserved; a stalled
    // output parks the new result in the skid entry and closes in_ready for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= UOP_RST;
            skid_q       <= UOP_RST;
            skid_empty_q <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_empty_q <= 1'b1;
        end else if (!out_valid_q || bus.out_ready) begin
            if (!skid_empty_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_empty_q <= 1'b1;
            end else if (in_fire) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= dec;
            skid_empty_q <= 1'b0;
        end
    end
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    // Single pipeline register: load on input transfer, drain on output transfer, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= UOP_RST;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.alu_op    = out_q.op;
    assign bus.operand_a = out_q.a;
    assign bus.operand_b = out_q.b;
    assign bus.rd        = out_q.rd;
    assign bus.rd_we     = out_q.we;
    assign bus.illegal   = out_q.ill;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU interface: decodes RV32I integer-ALU instructions (OP, OP-IMM, LUI, AUIPC) into an ALU opcode plus selected operands.
- Holds them in a valid/ready pipeline register feeding the execute stage, where the ALU consumes them.
- Sits between the register-file read and execute; flags non-ALU or malformed encodings as illegal.

Parameters:
XLEN, 32, datapath width; only 32 is supported (shift amounts are 5 bits).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage accepts upstream this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
in_rs1_data  in  XLEN  register-file value of rs1
in_rs2_data  in  XLEN  register-file value of rs2
out_valid  out  1  registered decode result valid
out_ready  in  1  execute stage accepts result
alu_op  out  4  opcode, one of the `ALU_* codes from constants.sv
operand_a  out  XLEN  ALU operand A
operand_b  out  XLEN  ALU operand B
rd  out  5  destination register index
rd_we  out  1  write-back enable
illegal  out  1  instruction not a legal ALU-class encoding

Behaviour:
- Single clock, clk. rst_n is asynchronous active-low. On reset every output register is 0; alu_op resets to `ALU_ADD; out_valid is 0.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Without the skid entry (see Optional Feature), in_ready = !out_valid || out_ready (combinational).
- Latency: 1 cycle. An instruction accepted at edge N is presented at edge N+1.
- While out_valid && !out_ready, all outputs hold stable.
- Opcode 0010011 (OP-IMM):
  - funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND; operand_b = sign-extended instr[31:20].
  - 001: SLL, legal only when instr[31:25]=0000000.
  - 101: SRL when instr[31:25]=0000000, SRA when 0100000.
  - Shifts: operand_b = {27'b0, instr[24:20]}.
  - operand_a = in_rs1_data.
- Opcode 0110011 (OP):
  - funct7=0000000: funct3 000..111 map to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0100000: 000 maps to SUB, 101 maps to SRA.
  - a = rs1_data, b = rs2_data.
- Opcode 0110111 (LUI): ADD, a = 0, b = {instr[31:12], 12'b0}.
- Opcode 0010111 (AUIPC): ADD, a = in_pc, b = {instr[31:12], 12'b0}.
- Any other opcode, or a funct7/funct3 combination not listed above:
  - illegal=1, alu_op=`ALU_ADD, operands 0, rd_we=0.
  - Still consumes a slot and is presented with out_valid=1.
- rd = instr[11:7]. rd_we = !illegal && rd != 0 (x0 writes suppressed).
- flush:
  - Clears out_valid (and skid entry) at the next edge.
  - Any input transfer in the same cycle is discarded.
  - Takes priority over out_ready/in_valid. in_ready is not gated by flush.
- Reset mid-transfer: the held instruction is dropped; no output is produced after rst_n rises until a new input transfer.
- Decode is purely a function of the inputs sampled at the transfer edge; later changes to in_rs1_data or in_rs2_data have no effect.

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer; in_ready becomes a register equal to "skid empty", with no combinational path from out_ready.
  - If an input transfer occurs while the output is stalled, the decoded result goes to the skid entry and in_ready drops the next cycle.
  - When the output transfers, the skid entry moves to the output and in_ready rises.
  - Order is strictly preserved. Throughput is 1/cycle when not stalled.
- Undefined: single register only, in_ready as stated in Behaviour.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), rs1_data=0, out_ready=1 -> next cycle out_valid=1, alu_op=`ALU_ADD, a=0, b=0xFFFFFFFF, rd=1, rd_we=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> alu_op=`ALU_SUB, a=10, b=3, rd=3; SRAI x5,x6,3 (0x40335293) -> `ALU_SRA, b=3.
- LUI x2,0x12345 (0x12345137) -> `ALU_ADD, a=0, b=0x12345000, rd=2; AUIPC same imm, pc=0x100 -> a=0x100.
- SLLI with funct7=0100000 (0x40209093); opcode 0000011 -> illegal=1, rd_we=0, out_valid=1; ADDI x0,x0,1 -> rd_we=0, illegal=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, no instruction lost or duplicated. With ALU_ISSUE_SKID_EN, exactly two instructions accepted, then in_ready=0.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, the flushed input never appears. rst_n pulsed low mid-stall -> out_valid=0 immediately, alu_op=`ALU_ADD.
